// File: rtl/gun_heat_pkg.sv
// Shared types and defaults for the multi-channel gun heat manager.
package gun_heat_pkg;

  typedef enum logic [1:0] {
    READY,
    HOT,
    LOCKED
  } heat_state_t;

  localparam int unsigned DEF_CHANNELS      = 2;
  localparam int unsigned DEF_HEAT_W        = 4;
  localparam int unsigned DEF_FIRE_PERIOD   = 50_000_000;
  localparam int unsigned DEF_COOL_PERIOD   = 100_000_000;
  localparam int unsigned DEF_WARN_LEVEL    = 12;
  localparam int unsigned DEF_RECOVER_LEVEL = 4;

  function automatic int unsigned heat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/gun_heat_manager_tick_gen.sv
// Periodic tick: counts PERIOD-1 down to 0, tick high while the count is 0.
module tick_gen
  import gun_heat_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_FIRE_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned   CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || restart || count_q == '0) count_q <= RELOAD;
    else                                   count_q <= count_q - 1'b1;
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/gun_heat_manager.sv
// Per-channel saturating heat counters with overheat lockout, driven by shared
// fire/cool ticks. Optional venting input enabled by GUN_HEAT_VENT_EN.
module gun_heat_manager
  import gun_heat_pkg::*;
#(
  parameter int unsigned CHANNELS      = DEF_CHANNELS,
  parameter int unsigned HEAT_W        = DEF_HEAT_W,
  parameter int unsigned FIRE_PERIOD   = DEF_FIRE_PERIOD,
  parameter int unsigned COOL_PERIOD   = DEF_COOL_PERIOD,
  parameter int unsigned WARN_LEVEL    = DEF_WARN_LEVEL,
  parameter int unsigned RECOVER_LEVEL = DEF_RECOVER_LEVEL
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_game,
  input  logic [CHANNELS-1:0]        shoot,
`ifdef GUN_HEAT_VENT_EN
  input  logic [CHANNELS-1:0]        vent,
`endif
  output logic [CHANNELS*HEAT_W-1:0] heat,
  output logic [CHANNELS-1:0]        fire_pulse,
  output logic [CHANNELS-1:0]        warn,
  output logic [CHANNELS-1:0]        overheat
);

  localparam logic [HEAT_W-1:0] HEAT_MAX  = HEAT_W'(heat_max(HEAT_W));
  localparam logic [HEAT_W-1:0] WARN_L    = HEAT_W'(WARN_LEVEL);
  localparam logic [HEAT_W-1:0] RECOVER_L = HEAT_W'(RECOVER_LEVEL);

  logic fire_tick;
  logic cool_tick;

  tick_gen #(.PERIOD(FIRE_PERIOD)) u_fire_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (start_game),
    .tick    (fire_tick)
  );

  tick_gen #(.PERIOD(COOL_PERIOD)) u_cool_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (start_game),
    .tick    (cool_tick)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    heat_state_t       state_q, state_d;
    logic [HEAT_W-1:0] heat_q, heat_d;
    logic              fire_q, fire_d;
    logic              vent_i, locked, inc, dec_cool, dec_vent;
    logic              warn_c, ov_c;

`ifdef GUN_HEAT_VENT_EN
    assign vent_i = vent[i];
`else
    assign vent_i = 1'b0;
`endif

    always_ff @(posedge clock) begin
      if (reset || start_game) begin
        state_q <= READY;
        heat_q  <= '0;
        fire_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        heat_q  <= heat_d;
        fire_q  <= fire_d;
      end
    end

    // inc and the decrements are mutually exclusive by construction, so shoot
    // alone picks the action when both ticks coincide.
    always_comb begin
      locked   = (state_q == LOCKED);
      inc      = fire_tick && shoot[i] && !locked;
      dec_cool = cool_tick && (locked || !shoot[i]);
      dec_vent = fire_tick && vent_i && !shoot[i];
      heat_d   = heat_q;
      fire_d   = inc;
      if (inc && heat_q != HEAT_MAX) heat_d = heat_q + 1'b1;
      if (dec_cool && heat_d != '0)  heat_d = heat_d - 1'b1;
      if (dec_vent && heat_d != '0)  heat_d = heat_d - 1'b1;

      state_d = state_q;
      if (locked)                  state_d = (heat_d <= RECOVER_L) ? READY : LOCKED;
      else if (heat_d == HEAT_MAX) state_d = LOCKED;
      else if (heat_d >= WARN_L)   state_d = HOT;
      else                         state_d = READY;
    end

    always_comb begin
      warn_c = (state_q == HOT) || (state_q == LOCKED);
      ov_c   = (state_q == LOCKED);
    end

    assign heat[i*HEAT_W +: HEAT_W] = heat_q;
    assign fire_pulse[i]            = fire_q;
    assign warn[i]                  = warn_c;
    assign overheat[i]              = ov_c;
  end

endmodule

// File: tb/tb_gun_heat_manager.sv
// Scoreboard bench for gun_heat_manager: expected output snapshots are queued
// per cycle by the stimulus and checked by an independent negedge monitor.
module tb_gun_heat_manager;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_game = 1'b0;
  logic [1:0] shoot = '0;
  logic [1:0] vent = '0;
  logic [5:0] heat;
  logic [1:0] fire_pulse, warn, overheat;

  gun_heat_manager #(
    .CHANNELS(2), .HEAT_W(3), .FIRE_PERIOD(4), .COOL_PERIOD(8),
    .WARN_LEVEL(5), .RECOVER_LEVEL(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_game (start_game),
    .shoot      (shoot),
`ifdef GUN_HEAT_VENT_EN
    .vent       (vent),
`endif
    .heat       (heat),
    .fire_pulse (fire_pulse),
    .warn       (warn),
    .overheat   (overheat)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned at;
    string       name;
    logic [5:0]  heat;
    logic [1:0]  fp, warn, ov;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  int unsigned checks = 0;
  int unsigned fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (mon_e.at != cyc) begin
        fails++;
        $display("FAIL %s: check due at cycle %0d missed, now %0d", mon_e.name, mon_e.at, cyc);
      end else if ({heat, fire_pulse, warn, overheat} !== {mon_e.heat, mon_e.fp, mon_e.warn, mon_e.ov}) begin
        fails++;
        $display("FAIL %s @%0d: got heat1=%0d heat0=%0d fp=%b warn=%b ov=%b, want heat1=%0d heat0=%0d fp=%b warn=%b ov=%b",
                 mon_e.name, cyc - t0, heat[5:3], heat[2:0], fire_pulse, warn, overheat,
                 mon_e.heat[5:3], mon_e.heat[2:0], mon_e.fp, mon_e.warn, mon_e.ov);
      end
    end
  end

  task automatic chk(input int unsigned k, input string nm, input logic [2:0] h0,
                     input logic [2:0] h1, input logic [1:0] fp, input logic [1:0] w,
                     input logic [1:0] o);
    exp_t e;
    e.at = t0 + k; e.name = nm; e.heat = {h1, h0}; e.fp = fp; e.warn = w; e.ov = o;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int unsigned k);
    while (cyc < t0 + k) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    t0 = cyc;
    reset = 1'b0;
  endtask

  initial begin
    // Phase A: heat up channel 0 to lockout, cool down while held, floor at 0.
    shoot = 2'b01;
    do_reset();
    chk(0, "reset_state", 3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 7; k++) begin
      chk(4 * k,     "heat_up",   3'(k), 3'd0, 2'b01, {1'b0, k >= 5}, {1'b0, k == 7});
      chk(4 * k + 1, "pulse_end", 3'(k), 3'd0, 2'b00, {1'b0, k >= 5}, {1'b0, k == 7});
    end
    chk(30, "no_over_max",  3'd7, 3'd0, 2'b00, 2'b01, 2'b01);
    chk(32, "lock_cool6",   3'd6, 3'd0, 2'b00, 2'b01, 2'b01);
    chk(36, "lock_no_fire", 3'd6, 3'd0, 2'b00, 2'b01, 2'b01);
    chk(40, "lock_cool5",   3'd5, 3'd0, 2'b00, 2'b01, 2'b01);
    chk(48, "lock_cool4",   3'd4, 3'd0, 2'b00, 2'b01, 2'b01);
    chk(56, "lock_cool3",   3'd3, 3'd0, 2'b00, 2'b01, 2'b01);
    chk(64, "recover2",     3'd2, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(72, "cool1",        3'd1, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(80, "cool0",        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(88, "floor0_a",     3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(96, "floor0_b",     3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    wait_until(64);
    shoot = 2'b00;
    wait_until(98);

    // Phase B: coincident ticks pick one action; off-tick shoot pulse ignored.
    shoot = 2'b11;
    do_reset();
    chk(4,  "both_up1",      3'd1, 3'd1, 2'b11, 2'b00, 2'b00);
    chk(8,  "coinc_shoot",   3'd2, 3'd2, 2'b11, 2'b00, 2'b00);
    chk(12, "both_up3",      3'd3, 3'd3, 2'b11, 2'b00, 2'b00);
    chk(16, "coinc_split",   3'd2, 3'd4, 2'b10, 2'b00, 2'b00);
    chk(20, "offtick_pulse", 3'd2, 3'd4, 2'b00, 2'b00, 2'b00);
    chk(24, "cool_both",     3'd1, 3'd3, 2'b00, 2'b00, 2'b00);
    wait_until(12);
    shoot = 2'b10;
    wait_until(16);
    shoot = 2'b00;
    wait_until(17);
    shoot = 2'b10;
    wait_until(18);
    shoot = 2'b00;
    wait_until(26);

    // Phase C: start_game and reset each clear a lockout and restart the ticks.
    shoot = 2'b01;
    do_reset();
    chk(28, "lock7",        3'd7, 3'd0, 2'b01, 2'b01, 2'b01);
    chk(32, "lock6",        3'd6, 3'd0, 2'b00, 2'b01, 2'b01);
    chk(33, "start_clear",  3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(36, "start_no_tick",3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(37, "start_tick",   3'd1, 3'd0, 2'b01, 2'b00, 2'b00);
    chk(61, "relock7",      3'd7, 3'd0, 2'b01, 2'b01, 2'b01);
    chk(65, "relock6",      3'd6, 3'd0, 2'b00, 2'b01, 2'b01);
    chk(66, "reset_clear",  3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(69, "reset_no_tick",3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(70, "reset_tick",   3'd1, 3'd0, 2'b01, 2'b00, 2'b00);
    wait_until(32);
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    wait_until(65);
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_until(72);

`ifdef GUN_HEAT_VENT_EN
    // Phase D: venting drains on fire ticks too, double on coincident ticks.
    shoot = 2'b01;
    vent  = 2'b00;
    do_reset();
    chk(24, "vent_start6", 3'd6, 3'd0, 2'b01, 2'b01, 2'b00);
    chk(28, "vent_fire5",  3'd5, 3'd0, 2'b00, 2'b01, 2'b00);
    chk(32, "vent_coinc3", 3'd3, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(36, "vent_fire2",  3'd2, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(40, "vent_coinc0", 3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(44, "vent_hold0",  3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    chk(48, "vent_hold0b", 3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    wait_until(24);
    shoot = 2'b00;
    vent  = 2'b01;
    wait_until(50);
    vent  = 2'b00;
`endif

    step();
    step();
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gun_heat_manager.md
# gun_heat_manager

Multi-channel, parametrised successor to the single-gun cooldown counter. One saturating heat counter per gun channel: it heats on a shared fire tick while the gun's shoot input is held and cools on a shared cool tick while released. Hitting maximum heat forces an overheat lockout that holds until the heat drops to a recovery level. The block sits between the player-input switches and the game logic/HUD; it grants shots with a fire pulse and exports heat, warning and lockout per channel.

## Interface
Parameters:
- CHANNELS, 2: number of independent gun channels.
- HEAT_W, 4: heat counter width; HEAT_MAX = 2^HEAT_W-1.
- FIRE_PERIOD, 50_000_000: clocks between fire ticks.
- COOL_PERIOD, 100_000_000: clocks between cool ticks.
- WARN_LEVEL, 12: heat at/above which warn asserts; must satisfy RECOVER_LEVEL < WARN_LEVEL < HEAT_MAX.
- RECOVER_LEVEL, 4: heat at/below which lockout releases.

Ports (reset is synchronous and active-high):
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous active-high reset.
- start_game  in  1  game-start strobe; clears all channels.
- shoot  in  CHANNELS  per-channel fire request, level.
- heat  out  CHANNELS*HEAT_W  packed heat counters; channel i at [i*HEAT_W +: HEAT_W].
- fire_pulse  out  CHANNELS  one-cycle shot grant.
- warn  out  CHANNELS  heat >= WARN_LEVEL.
- overheat  out  CHANNELS  channel locked out.

## Operation
- Two shared tick generators count down from PERIOD-1 to 0. Tick is high for the one cycle the count is 0, then the counter reloads PERIOD-1. Reset and start_game reload both counters.
- Per-channel FSM:
  - READY: heat < WARN_LEVEL.
  - HOT: WARN_LEVEL <= heat < HEAT_MAX.
  - LOCKED: entered when heat reaches HEAT_MAX.
- READY/HOT:
  - fire tick & shoot: heat += 1, saturating at HEAT_MAX; fire_pulse = 1.
  - cool tick & !shoot: heat -= 1, saturating at 0.
  - The state follows the new heat value.
- LOCKED:
  - shoot is ignored; fire_pulse is never asserted.
  - Every cool tick decrements heat, whether or not shoot is held.
  - LOCKED -> READY when the new heat <= RECOVER_LEVEL.
- Simultaneous fire and cool tick: shoot selects exactly one action. There is never a net change from both applying.
- Priority: reset > start_game > tick actions. start_game forces heat = 0 and state READY in all channels.
- Outputs:
  - warn = (state == HOT) or (state == LOCKED).
  - overheat = (state == LOCKED).
- Channels are fully independent apart from the shared ticks.

## Timing
- Reset values: heat = 0, fire_pulse = 0, warn = 0, overheat = 0, all FSMs READY, tick counters = PERIOD-1.
- All outputs are registered. Heat, state and flags update on the edge that samples the tick and are visible in the following cycle. fire_pulse is high for exactly that one cycle.
- The first fire tick after reset or start_game comes FIRE_PERIOD clocks later; the same applies to cool ticks with COOL_PERIOD.
- shoot is sampled only on tick cycles; pulses between ticks have no effect.
- Reset or start_game mid-lockout clears the lockout immediately.
- Saturation: no wrap at HEAT_MAX or at 0 under any input sequence.

## Configuration
- GUN_HEAT_VENT_EN defined:
  - Adds input vent [CHANNELS-1:0].
  - If vent & !shoot, fire ticks also decrement heat, saturating at 0. This applies in LOCKED as well.
  - Coincident fire and cool ticks then decrement by 2, saturating at 0.
- Undefined: no vent port; behaviour is exactly as above.

## Structure
- Shared package gun_heat_pkg holds:
  - the state enum (READY, HOT, LOCKED);
  - the default period and level constants;
  - a function returning the HEAT_MAX value for a given HEAT_W.
- Sub-module tick_gen (params PERIOD; ports clock, reset, restart, tick) is instantiated twice.
- The channel logic is a generate loop in gun_heat_manager.

## Test plan
Bench parameters: CHANNELS=2, HEAT_W=3, FIRE_PERIOD=4, COOL_PERIOD=8, WARN_LEVEL=5, RECOVER_LEVEL=2.
1. Reset, then hold shoot[0]=1 for 7 fire ticks: heat[0] steps 1..7 with one fire_pulse per tick, warn at 5, overheat at 7. Channel 1 stays at 0.
2. From LOCKED with shoot[0] still held: no fire_pulse; heat decrements each cool tick, 7→6→5→4→3→2; overheat clears on the update to 2; state READY with warn=0.
3. Heat 0 with shoot low for 3 cool ticks: heat stays 0 and no underflow. Heat 7 locked with shoot held: no increment above 7.
4. Coincident fire and cool tick (cycle 8k) with shoot[1]=1 at heat 3: heat becomes 4. With shoot[1]=0: heat becomes 2.
5. Assert start_game for one cycle while channel 0 is LOCKED at heat 6: next cycle heat = 0, overheat = 0, and the next fire tick occurs 4 clocks later. Reset asserted mid-run gives identical results.
6. With GUN_HEAT_VENT_EN defined, heat 6, vent=1, shoot=0: heat decrements on every fire tick plus cool tick, reaching 0 within 16 clocks and holding at 0.
